// File: rtl/cpu_defs.sv
// Shared definitions for the fetch side of the single-cycle MIPS core.
// Holds the fetch FSM encoding, reset PC, NOP and jump opcodes.
package cpu_defs;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    function automatic logic [31:0] word_align(
        input logic [31:0] addr
    );
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: jr, then j/jal, then taken branch,
// then the sequential PC+4.
module next_pc_sel
    import cpu_defs::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instrIndex,
    input  logic        branch,
    input  logic        nBranch,
    input  logic        jmp,
    input  logic        jal,
    input  logic        jr,
    input  logic        zero,
    input  logic [31:0] readData1,
    input  logic [31:0] extendedImm,
    output logic [31:0] pcPlus4,
    output logic [31:0] nextPc,
    output logic        branchTaken
);

    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;

    assign pcPlus4      = pc + 32'd4;
    assign branchTaken  = (branch && zero) || (nBranch && !zero);
    assign branchTarget = pcPlus4 + (extendedImm << 2);
    assign jumpTarget   = {pcPlus4[31:28], instrIndex, 2'b00};

    // Flags are not mutually exclusive, so this must stay a priority chain.
    always_comb begin
        nextPc = pcPlus4;
        if (jr) begin
            nextPc = word_align(readData1);
        end else if (jmp || jal) begin
            nextPc = jumpTarget;
        end else if (branchTaken) begin
            nextPc = branchTarget;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, BOOT/RUN/LOAD control and sync-read imem
// addressing, plus a UART program-load path into instruction memory.
module instruction_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          IMEM_ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch,
    input  logic                   nBranch,
    input  logic                   jmp,
    input  logic                   jal,
    input  logic                   jr,
    input  logic                   zero,
    input  logic [31:0]            readData1,
    input  logic [31:0]            extendedImm,
    input  logic                   stall,
    input  logic                   uartMode,
    input  logic                   uartWe,
    input  logic [IMEM_ADDR_W-1:0] uartAddr,
    input  logic [31:0]            uartData,
    input  logic [31:0]            imemData,
    output logic [IMEM_ADDR_W-1:0] imemAddr,
    output logic                   imemWe,
    output logic [IMEM_ADDR_W-1:0] imemWAddr,
    output logic [31:0]            imemWData,
    output logic [31:0]            instruction,
    output logic [31:0]            pc,
    output logic [31:0]            addressLink,
    output logic                   fetchValid,
    output logic                   branchTaken
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc_next;
    logic [31:0]  nextPc;
    logic [31:0]  pcPlus4;

    next_pc_sel u_next_pc_sel (
        .pc          (pc),
        .instrIndex  (instruction[25:0]),
        .branch      (branch),
        .nBranch     (nBranch),
        .jmp         (jmp),
        .jal         (jal),
        .jr          (jr),
        .zero        (zero),
        .readData1   (readData1),
        .extendedImm (extendedImm),
        .pcPlus4     (pcPlus4),
        .nextPc      (nextPc),
        .branchTaken (branchTaken)
    );

    assign addressLink = pcPlus4;
    assign imemWAddr   = uartAddr;
    assign imemWData   = uartData;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // imemAddr always points at the word that must appear next cycle,
    // so instruction lines up with pc despite the 1-cycle read.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        imemAddr    = pc[IMEM_ADDR_W+1:2];
        instruction = NOP;
        fetchValid  = 1'b0;
        imemWe      = 1'b0;
        case (state)
            BOOT: begin
                state_next = uartMode ? LOAD : RUN;
            end
            RUN: begin
                instruction = imemData;
                fetchValid  = 1'b1;
                if (uartMode) begin
                    state_next = LOAD;
                end else if (!stall) begin
                    pc_next  = nextPc;
                    imemAddr = nextPc[IMEM_ADDR_W+1:2];
                end
            end
            LOAD: begin
                imemWe = uartWe;
                if (!uartMode) begin
                    state_next = BOOT;
                    pc_next    = RESET_PC;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed flow checks plus
// randomized traffic against a behavioural fetch model.
module tb_instruction_fetch;
    import cpu_defs::*;

    localparam int AW    = 14;
    localparam int WORDS = 16384;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          branch = 0, nBranch = 0, jmp = 0, jal = 0, jr = 0;
    logic          zero = 0, stall = 0;
    logic [31:0]   readData1 = 0, extendedImm = 0;
    logic          uartMode = 0, uartWe = 0;
    logic [AW-1:0] uartAddr = 0;
    logic [31:0]   uartData = 0;
    logic [31:0]   imemData;
    logic [AW-1:0] imemAddr, imemWAddr;
    logic          imemWe, fetchValid, branchTaken;
    logic [31:0]   imemWData, instruction, pc, addressLink;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];

    // behavioural model state
    bit          started = 0;
    bit          m_run   = 0;
    bit          m_load  = 0;
    logic [31:0] mpc     = 0;

    instruction_fetch #(.RESET_PC(32'h0), .IMEM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .branch(branch), .nBranch(nBranch),
        .jmp(jmp), .jal(jal), .jr(jr), .zero(zero),
        .readData1(readData1), .extendedImm(extendedImm),
        .stall(stall), .uartMode(uartMode), .uartWe(uartWe),
        .uartAddr(uartAddr), .uartData(uartData),
        .imemData(imemData), .imemAddr(imemAddr),
        .imemWe(imemWe), .imemWAddr(imemWAddr),
        .imemWData(imemWData), .instruction(instruction),
        .pc(pc), .addressLink(addressLink),
        .fetchValid(fetchValid), .branchTaken(branchTaken)
    );

    always #5 clk = ~clk;

    // synchronous-read instruction memory
    always @(posedge clk) begin
        if (imemWe) mem[imemWAddr] <= imemWData;
        imemData <= mem[imemAddr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    function automatic bit ref_taken();
        return (branch && zero) || (nBranch && !zero);
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] p);
        logic [31:0] seq;
        logic [31:0] ins;
        seq = p + 4;
        ins = ref_mem[widx(p)];
        if (jr) return readData1 - (readData1 % 4);
        if (jmp || jal)
            return (seq & 32'hF000_0000) | ((ins % 32'h0400_0000) * 4);
        if (ref_taken()) return seq + extendedImm * 4;
        return seq;
    endfunction

    // model update, sampled on the same edge the DUT uses
    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            m_run   = 0;
            m_load  = 0;
            mpc     = 32'h0;
        end else if (started) begin
            if (m_load) begin
                if (uartWe) ref_mem[uartAddr] = uartData;
                if (!uartMode) begin
                    m_load = 0;
                    mpc    = 32'h0;
                end
            end else if (m_run) begin
                if (uartMode) begin
                    m_run  = 0;
                    m_load = 1;
                end else if (!stall) begin
                    mpc = ref_next(mpc);
                end
            end else begin
                m_run  = !uartMode;
                m_load = uartMode;
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("pc", pc, mpc);
            chk("addressLink", addressLink, mpc + 4);
            chk("fetchValid", 32'(fetchValid), 32'(m_run));
            chk("branchTaken", 32'(branchTaken), 32'(ref_taken()));
            chk("imemWe", 32'(imemWe), 32'(m_load && uartWe));
            if (m_run) begin
                chk("instruction", instruction, ref_mem[widx(mpc)]);
                if (!uartMode && !stall)
                    chk("imemAddr", 32'(imemAddr), widx(ref_next(mpc)));
                else
                    chk("imemAddr_hold", 32'(imemAddr), widx(mpc));
            end else begin
                chk("instruction_nop", instruction, NOP);
            end
            if (!m_run && !m_load)
                chk("imemAddr_boot", 32'(imemAddr), widx(mpc));
            if (m_load && uartWe) begin
                chk("imemWAddr", 32'(imemWAddr), 32'(uartAddr));
                chk("imemWData", imemWData, uartData);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flow();
        branch = 0; nBranch = 0; jmp = 0; jal = 0; jr = 0;
        zero = 0; stall = 0; extendedImm = 0; readData1 = 0;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        mem[8] = {OP_JAL, 26'h40};
        for (int i = 0; i < WORDS; i++) ref_mem[i] = mem[i];

        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        chk("boot_instr", instruction, 32'h0);
        chk("boot_valid", 32'(fetchValid), 32'h0);
        chk("boot_imemWe", 32'(imemWe), 32'h0);
        chk("boot_imemAddr", 32'(imemAddr), 32'h0);
        tick();
        chk("run_pc0", pc, 32'h0);
        chk("run_instr0", instruction, 32'h2008_0005);
        chk("run_link0", addressLink, 32'h4);
        chk("run_lead", 32'(imemAddr), 32'h1);
        tick();
        chk("seq_pc4", pc, 32'h4);
        tick();
        chk("seq_pc8", pc, 32'h8);
        chk("seq_valid", 32'(fetchValid), 32'h1);

        stall = 1;
        tick();
        chk("stall_pc", pc, 32'h8);
        chk("stall_instr", instruction, mem[2]);
        tick();
        chk("stall_pc2", pc, 32'h8);
        stall = 0;
        tick();
        chk("resume_pc", pc, 32'hC);

        jr = 1; readData1 = 32'h13;
        tick();
        chk("jr_pc10", pc, 32'h10);
        jr = 0;
        branch = 1; zero = 1; extendedImm = 32'hFFFF_FFFE;
        #1;
        chk("beq_taken", 32'(branchTaken), 32'h1);
        chk("beq_addr", 32'(imemAddr), 32'h3);
        zero = 0;
        #1;
        chk("beq_not", 32'(branchTaken), 32'h0);
        chk("beq_not_addr", 32'(imemAddr), 32'h5);
        branch = 0; nBranch = 1;
        #1;
        chk("bne_taken", 32'(branchTaken), 32'h1);
        nBranch = 0; branch = 1; zero = 1;
        tick();
        chk("beq_pc", pc, 32'hC);
        clear_flow();

        jr = 1; readData1 = 32'h20;
        tick();
        chk("at_jal_pc", pc, 32'h20);
        chk("jal_link", addressLink, 32'h24);
        chk("jal_instr", instruction, 32'h0C00_0040);
        jr = 0; jal = 1;
        tick();
        chk("jal_pc", pc, 32'h100);
        jal = 0; jr = 1; readData1 = 32'h203;
        tick();
        chk("jr_align", pc, 32'h200);
        jmp = 1; readData1 = 32'h44;
        tick();
        chk("jr_wins", pc, 32'h44);
        jmp = 0; readData1 = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_link", addressLink, 32'h0);
        clear_flow();
        tick();
        chk("wrap_zero", pc, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            branch      = ($urandom_range(0, 5) == 0);
            nBranch     = ($urandom_range(0, 5) == 0);
            jmp         = ($urandom_range(0, 11) == 0);
            jal         = ($urandom_range(0, 11) == 0);
            jr          = ($urandom_range(0, 15) == 0);
            zero        = $urandom_range(0, 1);
            stall       = ($urandom_range(0, 7) == 0);
            readData1   = $urandom;
            extendedImm = $urandom_range(0, 63) - 32;
            rst         = ($urandom_range(0, 299) == 0);
            if (!uartMode && $urandom_range(0, 99) == 0) uartMode = 1;
            else if (uartMode && $urandom_range(0, 3) == 0) uartMode = 0;
            uartWe   = $urandom_range(0, 1);
            uartAddr = AW'($urandom);
            uartData = $urandom;
            tick();
        end

        clear_flow();
        uartMode = 0; uartWe = 0; rst = 1;
        tick();
        rst = 0;
        tick();
        tick();
        tick();
        uartMode = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            uartWe   = 1;
            uartAddr = AW'(k);
            uartData = 32'hA5A5_0000 + k;
            #1;
            chk("load_we", 32'(imemWe), 32'h1);
            chk("load_instr", instruction, 32'h0);
            chk("load_valid", 32'(fetchValid), 32'h0);
            tick();
        end
        uartWe = 0;
        #1;
        chk("load_we_off", 32'(imemWe), 32'h0);
        uartMode = 0;
        tick();
        chk("reboot_pc", pc, 32'h0);
        chk("reboot_instr", instruction, 32'h0);
        tick();
        chk("loaded_instr", instruction, 32'hA5A5_0000);
        tick();
        chk("loaded_instr1", instruction, 32'hA5A5_0001);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream neighbour of the register-file/decoder stage in the single-cycle MIPS core.
- Owns the PC register, next-PC selection for sequential, branch, jump, jal and jr flow, and the synchronous-read instruction-memory address.
- Supplies `instruction` and `addressLink` (PC+4) to the decoder.
- Provides a UART program-load mode that freezes fetch and forwards writes into instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset and after program load
IMEM_ADDR_W, 14, word-address width of instruction memory

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
branch  in  1  beq decoded
nBranch  in  1  bne decoded
jmp  in  1  j decoded
jal  in  1  jal decoded
jr  in  1  jr decoded
zero  in  1  ALU zero flag
readData1  in  32  rs value (jr target)
extendedImm  in  32  sign-extended branch offset from decoder
stall  in  1  hold PC and current instruction
uartMode  in  1  program-load mode request
uartWe  in  1  UART write strobe
uartAddr  in  IMEM_ADDR_W  UART word address
uartData  in  32  UART write data
imemData  in  32  instruction memory read data (1-cycle sync read)
imemAddr  out  IMEM_ADDR_W  instruction memory read word address
imemWe  out  1  instruction memory write enable
imemWAddr  out  IMEM_ADDR_W  write word address
imemWData  out  32  write data
instruction  out  32  current instruction; 0 (nop) when not valid
pc  out  32  current PC
addressLink  out  32  pc+4, combinational, for jal write-back
fetchValid  out  1  high only in RUN
branchTaken  out  1  taken-branch indicator, combinational

Behaviour:
- States: BOOT, RUN, LOAD. Reset sets state=BOOT, pc=RESET_PC. Reset has priority over every other input.
- Reset values: fetchValid=0, instruction=0, imemWe=0, imemAddr=RESET_PC[IMEM_ADDR_W+1:2].
- BOOT: lasts exactly 1 cycle.
  - imemAddr = pc word address, which primes the sync read.
  - instruction=0; pc holds.
  - Next state is RUN, or LOAD if uartMode=1.
- RUN:
  - instruction = imemData; fetchValid=1.
  - Each edge, pc <= nextPc unless stall=1.
  - imemAddr = nextPc[IMEM_ADDR_W+1:2] when not stalled, pc[IMEM_ADDR_W+1:2] when stalled.
  - Read latency is 1 cycle, so `instruction` always matches `pc`.
- nextPc priority, highest first:
  1. jr: {readData1[31:2],2'b00}. Low bits forced to 0.
  2. jmp or jal: {pcPlus4[31:28], instruction[25:0], 2'b00}.
  3. Taken branch: pcPlus4 + (extendedImm<<2), 32-bit wrap-around. Taken = (branch&&zero) || (nBranch&&!zero).
  4. Otherwise pcPlus4.
- pcPlus4 = pc+4, 32-bit wrap. addressLink = pcPlus4 in every state.
- Simultaneous branch and jump flags: priority above applies. branchTaken still reports the branch condition.
- stall in BOOT or LOAD: no effect.
- LOAD:
  - Entered from any state on the edge where uartMode=1.
  - imemWe=uartWe, imemWAddr=uartAddr, imemWData=uartData. Outside LOAD, imemWe=0.
  - instruction=0, fetchValid=0, pc held.
  - On the edge where uartMode=0: pc <= RESET_PC, state <= BOOT.
- uartMode asserted mid-instruction: the current instruction is abandoned and no further PC update occurs. An in-flight write-back is the decoder's concern.
- PC wrap: pc=32'hFFFF_FFFC advances to 0.
- imemAddr truncates the PC. Addresses beyond memory alias; no error is flagged.

Decomposition:
- Shared package `cpu_defs`:
  - state encoding (BOOT=2'd0, RUN=2'd1, LOAD=2'd2)
  - NOP constant 32'h0
  - RESET_PC default
  - opcode constants J=6'b000010, JAL=6'b000011
- Optional sub-module `next_pc_sel`: purely combinational priority mux producing nextPc and branchTaken. The FSM and PC register stay in the top.

Test Plan:
- Reset, then release with the ROM holding 0x20080005 at word 0 → BOOT for 1 cycle (instruction=0); RUN next cycle with pc=0, instruction=0x20080005, addressLink=4.
- Sequential run over 3 cycles → pc 0, 4, 8; imemAddr leads pc by one word; fetchValid=1.
- beq with zero=1 at pc=0x10, extendedImm=0xFFFFFFFE → next pc=0x0C, branchTaken=1. Same with zero=0 → 0x14. bne with zero=0 → taken.
- Jumps:
  - jal 0x0000040 at pc=0x20 → addressLink=0x24, next pc=0x100.
  - jr with readData1=0x0000_0203 → next pc=0x200.
  - jr and jmp both high → jr wins.
- stall=1 for 2 cycles at pc=0x8 → pc and instruction unchanged; resumes at 0xC.
- uartMode=1 mid-run, 3 writes (addr 0..2) → imemWe mirrors uartWe, instruction=0. uartMode=0 → BOOT, pc=RESET_PC, first fetched instruction equals the word written at addr 0.
